// File: rtl/reg_op_sequencer_if.sv
// Command/drive bus between the control unit (master) and reg_op_sequencer (slave).
// Carries the command handshake, the register-bank drive lines and the shadow read port.
interface reg_op_sequencer_if #(
   parameter int NUM_REGS = 4,
   parameter int SEL_W    = 2,
   parameter int CNT_W    = 8
);
   logic                CmdValid;
   logic                CmdReady;
   logic [2:0]          CmdOp;
   logic [SEL_W-1:0]    CmdSel;
   logic [15:0]         CmdData;
   logic [CNT_W-1:0]    CmdCount;
   logic [NUM_REGS-1:0] RegE;
   logic [2:0]          RegFunSel;
   logic [15:0]         RegI;
   logic                Busy;
   logic                Done;
   logic                Err;
   logic [SEL_W-1:0]    ShadowSel;
   logic [15:0]         ShadowQ;

   modport master (
      output CmdValid, CmdOp, CmdSel, CmdData, CmdCount, ShadowSel,
      input  CmdReady, RegE, RegFunSel, RegI, Busy, Done, Err, ShadowQ
   );

   modport slave (
      input  CmdValid, CmdOp, CmdSel, CmdData, CmdCount, ShadowSel,
      output CmdReady, RegE, RegFunSel, RegI, Busy, Done, Err, ShadowQ
   );
endinterface

// File: rtl/reg_op_sequencer.sv
// Expands one register command into registered FunSel micro-ops; Done pulses ops+1 cycles after accept,
// commands accepted only in IDLE (no queueing). `define REG_SHADOW_EN adds per-register shadow copies.
module reg_op_sequencer #(
   parameter int NUM_REGS = 4,
   parameter int SEL_W    = 2,
   parameter int CNT_W    = 8
) (
   input logic               Clock,
   input logic               Reset,
   reg_op_sequencer_if.slave bus
);
   localparam logic [2:0] OP_LOAD16_BYTE = 3'b000;
   localparam logic [2:0] OP_LOAD16      = 3'b001;
   localparam logic [2:0] OP_CLEAR       = 3'b010;
   localparam logic [2:0] OP_INC_N       = 3'b011;
   localparam logic [2:0] OP_DEC_N       = 3'b100;
   localparam logic [2:0] OP_LOAD_LO     = 3'b101;

   localparam logic [2:0] FS_DEC     = 3'b000;
   localparam logic [2:0] FS_INC     = 3'b001;
   localparam logic [2:0] FS_LOAD    = 3'b010;
   localparam logic [2:0] FS_CLR     = 3'b011;
   localparam logic [2:0] FS_LO_ZERO = 3'b100;
   localparam logic [2:0] FS_LO_KEEP = 3'b101;
   localparam logic [2:0] FS_HI_KEEP = 3'b110;

   typedef enum logic [2:0] {IDLE, OP1, OP2, REPEAT, FIN} state_t;

   state_t              state;
   logic [2:0]          op_q;
   logic [SEL_W-1:0]    sel_q;
   logic [7:0]          data_hi_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [NUM_REGS-1:0] reg_e_q;
   logic [2:0]          fun_sel_q;
   logic [15:0]         reg_i_q;
   logic                done_q;
   logic                err_q;
   logic                cmd_bad;

   assign cmd_bad = (bus.CmdOp[2:1] == 2'b11) || (int'(bus.CmdSel) >= NUM_REGS);

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state     <= IDLE;
         op_q      <= OP_LOAD16_BYTE;
         sel_q     <= '0;
         data_hi_q <= '0;
         cnt_q     <= '0;
         reg_e_q   <= '0;
         fun_sel_q <= FS_DEC;
         reg_i_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.CmdValid) begin
                  op_q      <= bus.CmdOp;
                  sel_q     <= bus.CmdSel;
                  data_hi_q <= bus.CmdData[15:8];
                  if (cmd_bad) begin
                     state  <= FIN;
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end else begin
                     case (bus.CmdOp)
                        OP_LOAD16_BYTE: begin
                           state     <= OP1;
                           reg_e_q   <= NUM_REGS'(1) << bus.CmdSel;
                           fun_sel_q <= FS_LO_ZERO;
                           reg_i_q   <= {8'h00, bus.CmdData[7:0]};
                        end
                        OP_LOAD16: begin
                           state     <= OP1;
                           reg_e_q   <= NUM_REGS'(1) << bus.CmdSel;
                           fun_sel_q <= FS_LOAD;
                           reg_i_q   <= bus.CmdData;
                        end
                        OP_CLEAR: begin
                           state     <= OP1;
                           reg_e_q   <= NUM_REGS'(1) << bus.CmdSel;
                           fun_sel_q <= FS_CLR;
                           reg_i_q   <= '0;
                        end
                        OP_LOAD_LO: begin
                           state     <= OP1;
                           reg_e_q   <= NUM_REGS'(1) << bus.CmdSel;
                           fun_sel_q <= FS_LO_KEEP;
                           reg_i_q   <= {8'h00, bus.CmdData[7:0]};
                        end
                        OP_INC_N, OP_DEC_N: begin
                           // cnt_q holds the micro-ops still owed after the one being issued
                           if (bus.CmdCount == '0) begin
                              state  <= FIN;
                              done_q <= 1'b1;
                           end else begin
                              state     <= REPEAT;
                              reg_e_q   <= NUM_REGS'(1) << bus.CmdSel;
                              fun_sel_q <= (bus.CmdOp == OP_INC_N) ? FS_INC : FS_DEC;
                              reg_i_q   <= '0;
                              cnt_q     <= bus.CmdCount - CNT_W'(1);
                           end
                        end
                        default: begin
                           state  <= FIN;
                           done_q <= 1'b1;
                           err_q  <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            OP1: begin
               if (op_q == OP_LOAD16_BYTE) begin
                  state     <= OP2;
                  fun_sel_q <= FS_HI_KEEP;
                  reg_i_q   <= {8'h00, data_hi_q};
               end else begin
                  state     <= FIN;
                  reg_e_q   <= '0;
                  fun_sel_q <= FS_DEC;
                  reg_i_q   <= '0;
                  done_q    <= 1'b1;
               end
            end
            OP2: begin
               state     <= FIN;
               reg_e_q   <= '0;
               fun_sel_q <= FS_DEC;
               reg_i_q   <= '0;
               done_q    <= 1'b1;
            end
            REPEAT: begin
               if (cnt_q == '0) begin
                  state     <= FIN;
                  reg_e_q   <= '0;
                  fun_sel_q <= FS_DEC;
                  reg_i_q   <= '0;
                  done_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            FIN: begin
               state  <= IDLE;
               done_q <= 1'b0;
               err_q  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.CmdReady  = (state == IDLE);
   assign bus.Busy      = (state != IDLE);
   assign bus.RegE      = reg_e_q;
   assign bus.RegFunSel = fun_sel_q;
   assign bus.RegI      = reg_i_q;
   assign bus.Done      = done_q;
   assign bus.Err       = err_q;

`ifdef REG_SHADOW_EN
   logic [15:0] shadow [NUM_REGS];

   // Updated at the same edge the target register captures the issued micro-op
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      end else if (|reg_e_q) begin
         case (fun_sel_q)
            FS_DEC:     shadow[sel_q] <= shadow[sel_q] - 16'd1;
            FS_INC:     shadow[sel_q] <= shadow[sel_q] + 16'd1;
            FS_LOAD:    shadow[sel_q] <= reg_i_q;
            FS_CLR:     shadow[sel_q] <= '0;
            FS_LO_ZERO: shadow[sel_q] <= {8'h00, reg_i_q[7:0]};
            FS_LO_KEEP: shadow[sel_q] <= {shadow[sel_q][15:8], reg_i_q[7:0]};
            FS_HI_KEEP: shadow[sel_q] <= {reg_i_q[7:0], shadow[sel_q][7:0]};
            default:    ;
         endcase
      end
   end

   assign bus.ShadowQ = (int'(bus.ShadowSel) < NUM_REGS) ? shadow[bus.ShadowSel] : 16'h0000;
`else
   logic unused_shadow;
   assign unused_shadow = ^{bus.ShadowSel, sel_q};
   assign bus.ShadowQ   = 16'h0000;
`endif
endmodule

// File: tb/tb_reg_op_sequencer.sv
// Randomized bench for reg_op_sequencer: command-level register model plus a FunSel-driven bank.
module tb_reg_op_sequencer;
   localparam int NUM_REGS = 4;
   localparam int SEL_W    = 2;
   localparam int CNT_W    = 8;

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 Clock = ~Clock;

   reg_op_sequencer_if #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

   reg_op_sequencer #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   logic [15:0] bank  [NUM_REGS];
   logic [15:0] mregs [NUM_REGS];

   // Register bank as the real RF/ARF would behave under the DUT's drive lines
   always @(posedge Clock) begin
      if (!Reset) begin
         for (int i = 0; i < NUM_REGS; i++) bank[i] <= 16'h0000;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.RegE[i]) begin
               case (bus.RegFunSel)
                  3'b000: bank[i] <= bank[i] - 16'd1;
                  3'b001: bank[i] <= bank[i] + 16'd1;
                  3'b010: bank[i] <= bus.RegI;
                  3'b011: bank[i] <= 16'h0000;
                  3'b100: bank[i] <= {8'h00, bus.RegI[7:0]};
                  3'b101: bank[i] <= {bank[i][15:8], bus.RegI[7:0]};
                  3'b110: bank[i] <= {bus.RegI[7:0], bank[i][7:0]};
                  default: ;
               endcase
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_regs();
      for (int i = 0; i < NUM_REGS; i++) begin
         bus.ShadowSel = SEL_W'(i);
         #1;
`ifdef REG_SHADOW_EN
         check("shadow", 32'(bus.ShadowQ), 32'(mregs[i]));
`else
         check("shadow_tied", 32'(bus.ShadowQ), 32'h0);
`endif
         check("bank", 32'(bank[i]), 32'(mregs[i]));
      end
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [1:0] sel,
                          input logic [15:0] data, input logic [7:0] cnt);
      int          n;
      int          w;
      logic        bad;
      logic [2:0]  fs;
      logic [15:0] ri;
      logic [3:0]  e;

      bad = (op[2:1] == 2'b11);
      case (op)
         3'b000:         n = 2;
         3'b011, 3'b100: n = int'(cnt);
         3'b110, 3'b111: n = 0;
         default:        n = 1;
      endcase
      e = 4'b0001 << sel;

      @(negedge Clock);
      w = 0;
      while (!bus.CmdReady && w < 400) begin
         @(negedge Clock);
         w++;
      end
      check("ready_before_cmd", 32'(bus.CmdReady), 32'h1);

      bus.CmdValid = 1'b1;
      bus.CmdOp    = op;
      bus.CmdSel   = sel;
      bus.CmdData  = data;
      bus.CmdCount = cnt;
      @(negedge Clock);

      for (int k = 0; k < n; k++) begin
         fs = 3'b000;
         ri = 16'h0000;
         case (op)
            3'b000: begin
               fs = (k == 0) ? 3'b100 : 3'b110;
               ri = (k == 0) ? {8'h00, data[7:0]} : {8'h00, data[15:8]};
            end
            3'b001: begin fs = 3'b010; ri = data; end
            3'b010: begin fs = 3'b011; ri = 16'h0000; end
            3'b011: fs = 3'b001;
            3'b100: fs = 3'b000;
            3'b101: begin fs = 3'b101; ri = {8'h00, data[7:0]}; end
            default: ;
         endcase
         check("step_rege", 32'(bus.RegE), 32'(e));
         check("step_funsel", 32'(bus.RegFunSel), 32'(fs));
         check("step_regi", 32'(bus.RegI), 32'(ri));
         check("step_done", 32'(bus.Done), 32'h0);
         check("step_ready", 32'(bus.CmdReady), 32'h0);
         // commands presented while busy must be ignored
         bus.CmdValid = 1'($urandom_range(0, 1));
         bus.CmdOp    = 3'($urandom);
         bus.CmdSel   = 2'($urandom);
         bus.CmdData  = 16'($urandom);
         bus.CmdCount = 8'($urandom);
         @(negedge Clock);
      end

      check("fin_done", 32'(bus.Done), 32'h1);
      check("fin_err", 32'(bus.Err), 32'(bad));
      check("fin_rege", 32'(bus.RegE), 32'h0);
      check("fin_busy", 32'(bus.Busy), 32'h1);
      bus.CmdValid = 1'b0;
      @(negedge Clock);
      check("idle_done", 32'(bus.Done), 32'h0);
      check("idle_err", 32'(bus.Err), 32'h0);
      check("idle_ready", 32'(bus.CmdReady), 32'h1);
      check("idle_outs", 32'({bus.RegE, bus.RegFunSel, bus.RegI}), 32'h0);

      case (op)
         3'b000, 3'b001: mregs[sel] = data;
         3'b010:         mregs[sel] = 16'h0000;
         3'b011:         mregs[sel] = mregs[sel] + {8'h00, cnt};
         3'b100:         mregs[sel] = mregs[sel] - {8'h00, cnt};
         3'b101:         mregs[sel] = {mregs[sel][15:8], data[7:0]};
         default: ;
      endcase
      check_regs();
   endtask

   initial begin
      logic [2:0] rop;
      bus.CmdValid  = 1'b0;
      bus.CmdOp     = 3'b000;
      bus.CmdSel    = '0;
      bus.CmdData   = 16'h0000;
      bus.CmdCount  = '0;
      bus.ShadowSel = '0;
      for (int i = 0; i < NUM_REGS; i++) mregs[i] = 16'h0000;

      Reset = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      check("rst_rege", 32'(bus.RegE), 32'h0);
      check("rst_busy", 32'(bus.Busy), 32'h0);
      check("rst_ready", 32'(bus.CmdReady), 32'h1);
      check("rst_done", 32'(bus.Done), 32'h0);
      check("rst_err", 32'(bus.Err), 32'h0);
      check("rst_funsel_regi", 32'({bus.RegFunSel, bus.RegI}), 32'h0);
      check("rst_shadow", 32'(bus.ShadowQ), 32'h0);

      run_cmd(3'b000, 2'd2, 16'hBEEF, 8'd0);
      run_cmd(3'b001, 2'd0, 16'hFFFE, 8'd0);
      run_cmd(3'b011, 2'd0, 16'h0000, 8'd3);
      run_cmd(3'b100, 2'd1, 16'h5555, 8'd0);
      run_cmd(3'b111, 2'd3, 16'h1111, 8'd2);
      run_cmd(3'b001, 2'd1, 16'h1234, 8'd0);
      run_cmd(3'b101, 2'd1, 16'h00AB, 8'd0);
      run_cmd(3'b100, 2'd3, 16'h0000, 8'd255);
      run_cmd(3'b010, 2'd2, 16'hFFFF, 8'd0);
      run_cmd(3'b110, 2'd0, 16'hAAAA, 8'd1);

      // Reset landing on the second micro-op of a byte load
      @(negedge Clock);
      bus.CmdValid = 1'b1;
      bus.CmdOp    = 3'b000;
      bus.CmdSel   = 2'd3;
      bus.CmdData  = 16'hC0DE;
      @(negedge Clock);
      bus.CmdValid = 1'b0;
      @(negedge Clock);
      check("mid_op2_rege", 32'(bus.RegE), 32'h8);
      check("mid_op2_funsel", 32'(bus.RegFunSel), 32'h6);
      Reset = 1'b0;
      @(negedge Clock);
      check("mid_rst_rege", 32'(bus.RegE), 32'h0);
      check("mid_rst_done", 32'(bus.Done), 32'h0);
      check("mid_rst_busy", 32'(bus.Busy), 32'h0);
      @(negedge Clock);
      Reset = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) mregs[i] = 16'h0000;
      check("post_rst_ready", 32'(bus.CmdReady), 32'h1);
      check("post_rst_done", 32'(bus.Done), 32'h0);
      @(negedge Clock);
      check("post_rst_done2", 32'(bus.Done), 32'h0);
      check_regs();

      for (int t = 0; t < 60; t++) begin
         rop = 3'($urandom_range(0, 7));
         run_cmd(rop, 2'($urandom), 16'($urandom),
                 ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
